// File: rtl/serial_adder_nb.sv
// Digit-serial adder/subtractor: DIGIT bits per cycle through a ripple slice,
// carry registered between digits, start/busy/done framing with flags at completion.
module serial_adder_nb #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             C_out,
  output logic             Ofl,
  output logic             Zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_last;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_s;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             r_cout;
  logic             r_ofl;

  logic [DIGIT-1:0]       w_sum;
  logic                   w_slice_cout;
  logic                   w_slice_cmsb;
  logic [WIDTH+DIGIT-1:0] w_s_cat;
  logic [WIDTH-1:0]       w_s_nxt;

  assign w_last = (r_cnt == CW'(N - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Ripple chain kept in a procedural variable; the carry into the slice MSB
  // is retained because on the last digit that bit is the result sign bit.
  always_comb begin
    logic v_c;
    w_sum        = '0;
    w_slice_cmsb = 1'b0;
    v_c          = r_carry;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) w_slice_cmsb = v_c;
      w_sum[i] = r_a[i] ^ r_b[i] ^ v_c;
      v_c      = (r_a[i] & r_b[i]) | (v_c & (r_a[i] ^ r_b[i]));
    end
    w_slice_cout = v_c;
  end

  assign w_s_cat = {w_sum, r_s};
  assign w_s_nxt = w_s_cat[WIDTH+DIGIT-1:DIGIT];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_cout  <= 1'b0;
      r_ofl   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= A;
      r_b     <= sub ? ~B : B;
      r_carry <= sub ? 1'b1 : C_in;
      r_cnt   <= '0;
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_ofl   <= 1'b0;
    end else if (r_state == ST_RUN) begin
      r_a     <= r_a >> DIGIT;
      r_b     <= r_b >> DIGIT;
      r_s     <= w_s_nxt;
      r_carry <= w_slice_cout;
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) begin
        r_cout <= w_slice_cout;
        r_ofl  <= w_slice_cout ^ w_slice_cmsb;
      end
    end
  end

  assign busy  = (r_state == ST_RUN);
  assign done  = (r_state == ST_DONE);
  assign S     = r_s;
  assign C_out = r_cout;
  assign Ofl   = r_ofl;
  assign Zero  = (r_s == '0);

endmodule

// File: tb/tb_serial_adder_nb.sv
// Bench for serial_adder_nb: 16/4 and 8/1 instances, scoreboard queues popped on done.
module tb_serial_adder_nb;

  typedef struct packed {
    logic [15:0] s;
    logic        cout;
    logic        ofl;
  } exp_t;

  logic        clk;
  logic        rst;

  logic        start16, cin16, sub16;
  logic [15:0] a16, b16;
  logic        busy16, done16, cout16, ofl16, zero16;
  logic [15:0] s16;

  logic        start8, cin8, sub8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, cout8, ofl8, zero8;
  logic [7:0]  s8;

  exp_t q16[$];
  exp_t q8[$];
  exp_t m16, m8;
  int   n_checks;
  int   n_errors;

  serial_adder_nb #(.WIDTH(16), .DIGIT(4)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .A(a16), .B(b16), .C_in(cin16), .sub(sub16),
    .busy(busy16), .done(done16), .S(s16), .C_out(cout16), .Ofl(ofl16), .Zero(zero16)
  );

  serial_adder_nb #(.WIDTH(8), .DIGIT(1)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8), .C_in(cin8), .sub(sub8),
    .busy(busy8), .done(done8), .S(s8), .C_out(cout8), .Ofl(ofl8), .Zero(zero8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic sb);
    logic [16:0] mask;
    logic [16:0] full;
    logic [15:0] am;
    logic [15:0] bop;
    exp_t        e;
    mask   = (17'd1 << w) - 17'd1;
    am     = a & mask[15:0];
    bop    = (sb ? ~b : b) & mask[15:0];
    full   = {1'b0, am} + {1'b0, bop} + (sb ? 17'd1 : {16'd0, cin});
    e.s    = full[15:0] & mask[15:0];
    e.cout = full[w];
    e.ofl  = (am[w-1] == bop[w-1]) && (e.s[w-1] != am[w-1]);
    return e;
  endfunction

  task automatic drive16(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input logic sb, input bit push);
    a16 = a; b16 = b; cin16 = cin; sub16 = sb; start16 = 1'b1;
    if (push) q16.push_back(model(16, a, b, cin, sb));
    @(negedge clk);
    start16 = 1'b0;
    a16 = $urandom; b16 = $urandom; cin16 = $urandom; sub16 = $urandom;
  endtask

  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic sb);
    a8 = a; b8 = b; cin8 = cin; sub8 = sb; start8 = 1'b1;
    q8.push_back(model(8, {8'h00, a}, {8'h00, b}, cin, sb));
    @(negedge clk);
    start8 = 1'b0;
    a8 = $urandom; b8 = $urandom;
  endtask

  task automatic wait16(input int lat0, output int lat, output int nbusy);
    lat   = lat0;
    nbusy = busy16 ? 1 : 0;
    while (!done16 && lat < 40) begin
      @(negedge clk);
      lat++;
      if (busy16) nbusy++;
    end
  endtask

  task automatic wait8(output int lat);
    lat = 1;
    while (!done8 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy16, done16, s16, cout16, ofl16, zero16} !== {1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1}) begin
      n_errors++;
      $display("FAIL reset16: busy=%b done=%b S=%h C_out=%b Ofl=%b Zero=%b, expected 0 0 0000 0 0 1",
               busy16, done16, s16, cout16, ofl16, zero16);
    end
    n_checks++;
    if ({busy8, done8, s8, cout8, ofl8, zero8} !== {1'b0, 1'b0, 8'h0, 1'b0, 1'b0, 1'b1}) begin
      n_errors++;
      $display("FAIL reset8: busy=%b done=%b S=%h C_out=%b Ofl=%b Zero=%b, expected 0 0 00 0 0 1",
               busy8, done8, s8, cout8, ofl8, zero8);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add();
    int lat, nb;
    drive16(16'h1234, 16'h0FF0, 1'b0, 1'b0, 1'b1);
    wait16(1, lat, nb);
    n_checks++;
    if (lat !== 5) begin n_errors++; $display("FAIL add_latency: got %0d expected 5", lat); end
    n_checks++;
    if (nb !== 4) begin n_errors++; $display("FAIL add_busy_cycles: got %0d expected 4", nb); end
    repeat (2) @(negedge clk);
    n_checks++;
    if ({s16, busy16, done16} !== {16'h2224, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL add_hold: S=%h busy=%b done=%b, expected 2224 0 0", s16, busy16, done16);
    end
  endtask

  task automatic test_carry_ofl();
    int lat, nb;
    drive16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
    wait16(1, lat, nb);
    n_checks++;
    if (lat !== 5) begin n_errors++; $display("FAIL wrap_latency: got %0d expected 5", lat); end
    @(negedge clk);
    drive16(16'h7FFF, 16'h0000, 1'b1, 1'b0, 1'b1);
    wait16(1, lat, nb);
    n_checks++;
    if (lat !== 5) begin n_errors++; $display("FAIL ofl_latency: got %0d expected 5", lat); end
    @(negedge clk);
  endtask

  task automatic test_sub();
    int lat, nb;
    drive16(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1);
    wait16(1, lat, nb);
    @(negedge clk);
    drive16(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1);
    wait16(1, lat, nb);
    n_checks++;
    if (lat !== 5) begin n_errors++; $display("FAIL sub_latency: got %0d expected 5", lat); end
    @(negedge clk);
  endtask

  task automatic test_start_ignored();
    int lat, nb, extra;
    drive16(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1);
    a16 = 16'hAAAA; b16 = 16'h5555; sub16 = 1'b1; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    wait16(2, lat, nb);
    n_checks++;
    if (lat !== 5) begin n_errors++; $display("FAIL ignored_latency: got %0d expected 5", lat); end
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (done16 || busy16) extra++;
    end
    n_checks++;
    if (extra !== 0) begin n_errors++; $display("FAIL ignored_no_second_op: got %0d active cycles expected 0", extra); end
  endtask

  task automatic test_back_to_back();
    int lat, nb;
    drive16(16'h00FF, 16'h0F01, 1'b1, 1'b0, 1'b1);
    wait16(1, lat, nb);
    drive16(16'h4000, 16'h4000, 1'b0, 1'b0, 1'b1);
    wait16(1, lat, nb);
    n_checks++;
    if (lat !== 5) begin n_errors++; $display("FAIL b2b_latency: got %0d expected 5", lat); end
    n_checks++;
    if (nb !== 4) begin n_errors++; $display("FAIL b2b_busy_cycles: got %0d expected 4", nb); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int dn;
    drive16(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({busy16, done16, s16, zero16} !== {1'b0, 1'b0, 16'h0, 1'b1}) begin
      n_errors++;
      $display("FAIL reset_mid: busy=%b done=%b S=%h Zero=%b, expected 0 0 0000 1",
               busy16, done16, s16, zero16);
    end
    dn = 0;
    repeat (10) begin
      @(negedge clk);
      if (done16) dn++;
    end
    n_checks++;
    if (dn !== 0) begin n_errors++; $display("FAIL reset_mid_done: got %0d pulses expected 0", dn); end
  endtask

  task automatic test_digit1();
    int lat;
    drive8(8'h80, 8'h80, 1'b0, 1'b0);
    wait8(lat);
    n_checks++;
    if (lat !== 9) begin n_errors++; $display("FAIL d1_latency: got %0d expected 9", lat); end
    @(negedge clk);
  endtask

  task automatic test_random();
    int lat, nb;
    for (int i = 0; i < 20; i++) begin
      drive16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1);
      wait16(1, lat, nb);
      n_checks++;
      if (lat !== 5) begin n_errors++; $display("FAIL rand16_latency[%0d]: got %0d expected 5", i, lat); end
      if ($urandom_range(1, 0) == 1) @(negedge clk);
    end
    for (int i = 0; i < 20; i++) begin
      drive8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      wait8(lat);
      n_checks++;
      if (lat !== 9) begin n_errors++; $display("FAIL rand8_latency[%0d]: got %0d expected 9", i, lat); end
      @(negedge clk);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0;
    start8  = 1'b0; a8  = '0; b8  = '0; cin8  = 1'b0; sub8  = 1'b0;
    @(negedge clk);

    fork
      forever begin
        @(negedge clk);
        if (done16) begin
          n_checks++;
          if (q16.size() == 0) begin
            n_errors++;
            $display("FAIL sb16_unexpected_done: S=%h with no operation pending", s16);
          end else begin
            m16 = q16.pop_front();
            if ({s16, cout16, ofl16, zero16} !== {m16.s, m16.cout, m16.ofl, (m16.s == 16'h0)}) begin
              n_errors++;
              $display("FAIL sb16_result: S=%h C_out=%b Ofl=%b Zero=%b, expected S=%h C_out=%b Ofl=%b Zero=%b",
                       s16, cout16, ofl16, zero16, m16.s, m16.cout, m16.ofl, (m16.s == 16'h0));
            end
          end
        end
        if (done8) begin
          n_checks++;
          if (q8.size() == 0) begin
            n_errors++;
            $display("FAIL sb8_unexpected_done: S=%h with no operation pending", s8);
          end else begin
            m8 = q8.pop_front();
            if ({s8, cout8, ofl8, zero8} !== {m8.s[7:0], m8.cout, m8.ofl, (m8.s[7:0] == 8'h0)}) begin
              n_errors++;
              $display("FAIL sb8_result: S=%h C_out=%b Ofl=%b Zero=%b, expected S=%h C_out=%b Ofl=%b Zero=%b",
                       s8, cout8, ofl8, zero8, m8.s[7:0], m8.cout, m8.ofl, (m8.s[7:0] == 8'h0));
            end
          end
        end
      end
    join_none

    test_reset();
    test_add();
    test_carry_ofl();
    test_sub();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    test_digit1();
    test_random();

    repeat (3) @(negedge clk);
    n_checks++;
    if (q16.size() != 0 || q8.size() != 0) begin
      n_errors++;
      $display("FAIL sb_drain: %0d/%0d results still pending, expected 0/0", q16.size(), q8.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
